// File: rtl/st_align_pkg.sv
// Shared definitions for the store alignment unit: funct3 encodings, FSM states, size decode.
package st_align_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_RESP
  } state_t;

  // Store size in bytes; encodings with bit 2 set are not stores and report size 0.
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    return f3[2] ? 4'd0 : (4'd1 << f3[1:0]);
  endfunction

endpackage

// File: rtl/st_lane_shift.sv
// Purpose: place store bytes into a double-width lane window with a matching byte strobe.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module st_lane_shift
  import st_align_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OB   = $clog2(NB)
) (
  input  logic [XLEN-1:0]   data,
  input  logic [2:0]        funct3,
  input  logic [OB-1:0]     offset,
  output logic [2*XLEN-1:0] d2,
  output logic [2*NB-1:0]   m2
);

  logic [3:0]      size;
  logic [NB-1:0]   bmask;
  logic [XLEN-1:0] masked;

  always_comb begin
    size   = size_bytes(funct3);
    bmask  = '0;
    masked = '0;
    for (int i = 0; i < NB; i++) begin
      bmask[i]          = (i < int'(size));
      masked[8*i +: 8]  = bmask[i] ? data[8*i +: 8] : 8'h00;
    end
    // Bytes pushed past the top lane spill into the upper half and form the second beat.
    d2 = {{XLEN{1'b0}}, masked} << {offset, 3'b000};
    m2 = {{NB{1'b0}}, bmask} << offset;
  end

endmodule

// File: rtl/st_align_unit.sv
// Purpose: turn one store request into one or two aligned, strobed bus write beats.
// Latency: done 2 cycles after accept (1 beat) or 3 (2 beats). Backpressure: beats held while bus_ready=0; req_ready only in IDLE.
module st_align_unit
  import st_align_pkg::*;
#(
  parameter  int XLEN           = 32,
  parameter  bit ALLOW_MISALIGN = 1'b1,
  localparam int NB             = XLEN / 8,
  localparam int OB             = $clog2(NB)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_data,
  input  logic [2:0]      req_funct3,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [NB-1:0]   bus_wstrb,
  output logic            done,
  output logic            misalign_err
);

  state_t            state;
  logic [2*XLEN-1:0] d2;
  logic [2*NB-1:0]   m2;
  logic [XLEN-1:0]   hi_data;
  logic [NB-1:0]     hi_strb;
  logic              f3_illegal;
  logic              crosses;
  logic              reject;

  st_lane_shift #(.XLEN(XLEN)) u_lane_shift (
    .data   (req_data),
    .funct3 (req_funct3),
    .offset (req_addr[OB-1:0]),
    .d2     (d2),
    .m2     (m2)
  );

  // A store crosses the beat boundary exactly when any strobe bit lands in the upper half.
  assign f3_illegal = req_funct3[2] || ((XLEN == 32) && (req_funct3 == F3_SD));
  assign crosses    = |m2[2*NB-1:NB];
  assign reject     = f3_illegal || (!ALLOW_MISALIGN && crosses);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b1;
      bus_valid    <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_wstrb    <= '0;
      done         <= 1'b0;
      misalign_err <= 1'b0;
      hi_data      <= '0;
      hi_strb      <= '0;
    end else begin
      done         <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (reject) begin
              misalign_err <= 1'b1;
            end else begin
              state     <= ST_BEAT0;
              req_ready <= 1'b0;
              bus_valid <= 1'b1;
              bus_addr  <= {req_addr[XLEN-1:OB], {OB{1'b0}}};
              bus_wdata <= d2[XLEN-1:0];
              bus_wstrb <= m2[NB-1:0];
              hi_data   <= d2[2*XLEN-1:XLEN];
              hi_strb   <= m2[2*NB-1:NB];
            end
          end
        end
        ST_BEAT0: begin
          if (bus_ready) begin
            if (|hi_strb) begin
              state     <= ST_BEAT1;
              // Wraps modulo 2^XLEN at the top of the address space.
              bus_addr  <= bus_addr + XLEN'(NB);
              bus_wdata <= hi_data;
              bus_wstrb <= hi_strb;
            end else begin
              state     <= ST_RESP;
              bus_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        ST_BEAT1: begin
          if (bus_ready) begin
            state     <= ST_RESP;
            bus_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_st_align_unit.sv
// Directed bench for st_align_unit at XLEN=32, with split-enabled and trap-on-misalign instances.
module tb_st_align_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_valid0;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  req_funct3;
  logic        bus_ready;

  logic        req_ready,  req_ready0;
  logic        bus_valid,  bus_valid0;
  logic [31:0] bus_addr,   bus_addr0;
  logic [31:0] bus_wdata,  bus_wdata0;
  logic [3:0]  bus_wstrb,  bus_wstrb0;
  logic        done,       done0;
  logic        misalign_err, misalign_err0;

  int checks   = 0;
  int failures = 0;

  st_align_unit #(.XLEN(32), .ALLOW_MISALIGN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
    .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .done(done), .misalign_err(misalign_err)
  );

  st_align_unit #(.XLEN(32), .ALLOW_MISALIGN(1'b0)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
    .bus_valid(bus_valid0), .bus_ready(bus_ready),
    .bus_addr(bus_addr0), .bus_wdata(bus_wdata0), .bus_wstrb(bus_wstrb0),
    .done(done0), .misalign_err(misalign_err0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents a request for exactly one clock edge to the selected instance.
  task automatic send(input bit to_trap, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    req_addr   = a;
    req_data   = d;
    req_funct3 = f3;
    if (to_trap) req_valid0 = 1'b1;
    else         req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
    req_valid0 = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    chk({tag, ".valid"}, bus_valid, 1'b1);
    chk({tag, ".addr"},  bus_addr,  a);
    chk({tag, ".wdata"}, bus_wdata, d);
    chk({tag, ".wstrb"}, bus_wstrb, s);
    chk({tag, ".done"},  done,      1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_valid0 = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    req_funct3 = '0;
    bus_ready  = 1'b1;

    tick();
    chk("rst.req_ready", req_ready, 1'b1);
    chk("rst.bus_valid", bus_valid, 1'b0);
    chk("rst.bus_addr",  bus_addr,  32'h0);
    chk("rst.bus_wdata", bus_wdata, 32'h0);
    chk("rst.bus_wstrb", bus_wstrb, 4'h0);
    chk("rst.done",      done,      1'b0);
    chk("rst.err",       misalign_err, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // Aligned SW: single beat, done two cycles after accept.
    send(1'b0, 32'h100, 32'hDEADBEEF, 3'b010);
    chk_beat("sw", 32'h100, 32'hDEADBEEF, 4'b1111);
    chk("sw.req_ready", req_ready, 1'b0);
    tick();
    chk("sw.done", done, 1'b1);
    chk("sw.bus_valid_resp", bus_valid, 1'b0);
    tick();
    chk("sw.done_off", done, 1'b0);
    chk("sw.req_ready_back", req_ready, 1'b1);

    // SB into the top lane.
    send(1'b0, 32'h103, 32'h123456AB, 3'b000);
    chk_beat("sb", 32'h100, 32'hAB000000, 4'b1000);
    tick();
    chk("sb.done", done, 1'b1);
    tick();

    // Misaligned SW split over two beats.
    send(1'b0, 32'h0FE, 32'h11223344, 3'b010);
    chk_beat("mis.b0", 32'h0FC, 32'h33440000, 4'b1100);
    tick();
    chk_beat("mis.b1", 32'h100, 32'h00001122, 4'b0011);
    tick();
    chk("mis.done", done, 1'b1);
    chk("mis.bus_valid_resp", bus_valid, 1'b0);
    tick();
    chk("mis.done_off", done, 1'b0);

    // Same request on the trapping instance: error pulse, no bus traffic.
    send(1'b1, 32'h0FE, 32'h11223344, 3'b010);
    chk("trap.err", misalign_err0, 1'b1);
    chk("trap.bus_valid", bus_valid0, 1'b0);
    chk("trap.req_ready", req_ready0, 1'b1);
    tick();
    chk("trap.err_off", misalign_err0, 1'b0);
    chk("trap.bus_valid_after", bus_valid0, 1'b0);
    chk("trap.done", done0, 1'b0);

    // Trapping instance still handles aligned stores.
    send(1'b1, 32'h200, 32'hCAFEF00D, 3'b010);
    chk("trap_ok.valid", bus_valid0, 1'b1);
    chk("trap_ok.addr", bus_addr0, 32'h200);
    chk("trap_ok.wstrb", bus_wstrb0, 4'b1111);
    chk("trap_ok.err", misalign_err0, 1'b0);
    tick();
    chk("trap_ok.done", done0, 1'b1);
    tick();

    // SD is illegal at XLEN=32.
    send(1'b0, 32'h100, 32'h55555555, 3'b011);
    chk("sd32.err", misalign_err, 1'b1);
    chk("sd32.bus_valid", bus_valid, 1'b0);
    chk("sd32.req_ready", req_ready, 1'b1);
    tick();
    chk("sd32.err_off", misalign_err, 1'b0);

    // Backpressure: beat held stable for four stalled cycles.
    bus_ready = 1'b0;
    send(1'b0, 32'h2, 32'h0000ABCD, 3'b001);
    chk_beat("bp.accept", 32'h0, 32'hABCD0000, 4'b1100);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_beat($sformatf("bp.stall%0d", k), 32'h0, 32'hABCD0000, 4'b1100);
    end
    bus_ready = 1'b1;
    tick();
    chk("bp.done", done, 1'b1);
    chk("bp.bus_valid_resp", bus_valid, 1'b0);
    tick();

    // Beat-1 address wraps past the top of the address space.
    send(1'b0, 32'hFFFFFFFE, 32'hAABBCCDD, 3'b010);
    chk_beat("wrap.b0", 32'hFFFFFFFC, 32'hCCDD0000, 4'b1100);
    tick();
    chk_beat("wrap.b1", 32'h00000000, 32'h0000AABB, 4'b0011);
    tick();
    chk("wrap.done", done, 1'b1);
    tick();

    // Reset while in BEAT1 abandons the store immediately.
    send(1'b0, 32'h0FE, 32'h11223344, 3'b010);
    tick();
    chk("rbeat1.valid_pre", bus_valid, 1'b1);
    chk("rbeat1.addr_pre", bus_addr, 32'h100);
    reset = 1'b1;
    #1;
    chk("rbeat1.bus_valid", bus_valid, 1'b0);
    chk("rbeat1.req_ready", req_ready, 1'b1);
    #2;
    reset = 1'b0;
    tick();
    chk("rbeat1.done", done, 1'b0);
    chk("rbeat1.bus_valid_after", bus_valid, 1'b0);
    chk("rbeat1.req_ready_after", req_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/st_align_unit.md
Name: st_align_unit

Overview:
- Sequential successor to the combinational store-data converter; sits between the execute stage and the data-memory bus.
- Accepts one store request (address, data, funct3), then generates one or two aligned bus write beats. Each beat carries a lane-shifted data word and a byte strobe.
- Parametrised for 32- or 64-bit datapaths.
- Optionally splits misaligned stores into two beats; otherwise traps them.

Parameters:
- XLEN, 32, datapath/address width; legal values 32 or 64.
- ALLOW_MISALIGN, 1, 1 = split boundary-crossing stores into two beats; 0 = raise misalign_err, no bus traffic.
- Derived, not overridable: NB = XLEN/8 (bytes per beat); OB = log2(NB) (offset bits).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request.
- req_addr  in  XLEN  byte address of the store.
- req_data  in  XLEN  store data, right-justified.
- req_funct3  in  3  RISC-V store funct3: 000 SB, 001 SH, 010 SW, 011 SD (SD legal only when XLEN=64).
- bus_valid  out  1  write beat valid.
- bus_ready  in  1  memory accepts the beat.
- bus_addr  out  XLEN  beat address, NB-aligned.
- bus_wdata  out  XLEN  lane-aligned write data.
- bus_wstrb  out  NB  byte-write enables.
- done  out  1  one-cycle pulse: store completed.
- misalign_err  out  1  one-cycle pulse: request rejected (misaligned with ALLOW_MISALIGN=0, or illegal funct3).

Behaviour:
- Reset (async, active-high): state=IDLE; req_ready=1; bus_valid=0; bus_addr=0; bus_wdata=0; bus_wstrb=0; done=0; misalign_err=0.
- Reset mid-transaction abandons the transaction; bus_valid drops immediately. The partial beat-0 write is not undone.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request. Compute size S = 1<<funct3[1:0] and offset o = addr[OB-1:0].
  - Illegal funct3 (bit2=1, or 011 when XLEN=32), or o+S>NB with ALLOW_MISALIGN=0 -> pulse misalign_err next cycle, stay IDLE.
  - Otherwise -> BEAT0.
- Data placement:
  - Form a 2*XLEN value D2 = zero_ext(req_data masked to S bytes) << (8*o).
  - Form a 2*NB strobe M2 = ((1<<S)-1) << o.
  - Beat0 uses the low halves; beat1 uses the high halves.
  - Strobed byte lanes carry the data bytes; unstrobed lanes are 0.
- BEAT0:
  - bus_valid=1; bus_addr = addr with low OB bits cleared; bus_wdata/bus_wstrb = low halves.
  - Outputs are held stable while bus_ready=0.
  - On handshake: -> BEAT1 if the high strobe half is nonzero, else -> RESP.
- BEAT1:
  - bus_addr = beat0 address + NB, computed modulo 2^XLEN (wraps at top of address space).
  - Data/strobe = high halves.
  - On handshake -> RESP.
- RESP: done=1 for exactly one cycle, bus_valid=0, -> IDLE.
- Cycle counts:
  - Minimum latency, accept to done: 2 cycles for one beat, 3 cycles for two beats, assuming bus_ready is tied high.
  - Throughput is one store per 3 cycles (aligned).
- req_ready=0 in all states except IDLE. A req_valid outside IDLE is ignored and not queued.
- bus_valid never asserts in IDLE or RESP. No combinational path from bus_ready to bus_valid.
- Zero-length stores are impossible. The strobe is never all-zero while bus_valid=1.

Decomposition:
- Package st_align_pkg holds:
  - funct3 constants: F3_SB, F3_SH, F3_SW, F3_SD.
  - State enum: ST_IDLE, ST_BEAT0, ST_BEAT1, ST_RESP.
  - Function size_bytes(funct3).
- Sub-module st_lane_shift: purely combinational; (data, funct3, offset) -> {D2, M2}. Parametrised by XLEN.
- The FSM and output registers live in st_align_unit.

Test Plan:
- Aligned SW, XLEN=32, addr=0x100, data=0xDEADBEEF, bus_ready=1 -> one beat: bus_addr=0x100, wdata=0xDEADBEEF, wstrb=1111; done 2 cycles after accept.
- SB, XLEN=32, addr=0x103, data=0x123456AB -> bus_addr=0x100, wdata=0xAB000000, wstrb=1000.
- Misaligned SW, XLEN=32, ALLOW_MISALIGN=1, addr=0x0FE, data=0x11223344:
  - beat0: addr=0x0FC, wdata=0x33440000, wstrb=1100.
  - beat1: addr=0x100, wdata=0x00001122, wstrb=0011.
  - done 3 cycles after accept.
- Same request with ALLOW_MISALIGN=0 -> no bus_valid, misalign_err pulses 1 cycle, req_ready stays 1. Also SD (funct3=011) at XLEN=32 -> misalign_err.
- Backpressure: SH at addr=0x2, bus_ready=0 for 4 cycles -> bus_addr/wdata/wstrb stable (0x0, data<<16, 1100) throughout; done 1 cycle after bus_ready rises.
- Wrap and reset:
  - XLEN=32, SW at addr=0xFFFFFFFE -> beat1 addr=0x00000000, wstrb=0011.
  - Assert reset during BEAT1 -> bus_valid=0 same cycle, req_ready=1, no done pulse.
